pc_gen: RTL and testbench
=========================

# pc_gen

Registered program-counter generator for the pipelined core. It owns the fetch PC, resolves branches and jumps arriving from EX, and redirects fetch on exceptions and mispredictions. It also predicts function returns at ID with a parametrised return-address stack (RAS). It sits between the IF stage (drives `if_pc`) and the ID/EX stages (consumes their resolution and hint signals), and supersedes the purely combinational next-PC mux.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `RESET_PC`, 32'h0000_0000: `if_pc` value after reset.
- `EXC_VECTOR`, 32'h1C09_0000: exception target.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.

Ports (clock and reset first):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold `if_pc`; ID hints ignored.
- `exc`  in  1  exception taken this cycle.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_branch`  in  4  `BRANCH_*` code from `ctrl_encode_def.v`.
- `ex_zero`, `ex_lt`  in  1 each  ALU compare flags.
- `ex_pc`, `ex_rs1`, `ex_imm`  in  XLEN each  EX operands.
- `ex_pred_taken`  in  1  ID prediction carried down the pipe.
- `ex_pred_target`  in  XLEN  predicted target carried down the pipe.
- `id_valid`, `id_is_call`, `id_is_ret`  in  1 each  ID hints.
  - Call: JAL/JALR with rd ∈ {x1, x5}.
  - Ret: JALR with rs1 ∈ {x1, x5} and rd = x0.
- `id_pc`  in  XLEN  ID instruction address.
- `if_pc`  out  XLEN  registered fetch address.
- `redirect`  out  1  combinational; flush IF/ID and ID/EX this cycle.
- `id_pred_taken`  out  1  combinational return prediction.
- `id_pred_target`  out  XLEN  predicted return address (RAS top).

## Operation
- EX resolution applies when `ex_valid` is high.
  - Branch taken conditions:
    - BEQ: zero. BNE: ~zero.
    - BLT and BLTU: lt. BGE and BGEU: ~lt.
    - JAL and JALR: always taken.
  - Target: `ex_pc+ex_imm`, except JALR, which uses `(ex_rs1+ex_imm) & ~1`.
  - Conditional branches and JAL are predicted not-taken.
- Mispredict rules:
  - Non-JALR: mispredict when the branch is taken.
  - JALR: mispredict when `!ex_pred_taken` or target ≠ `ex_pred_target`.
- Next-PC priority, highest first:
  1. `exc` → `EXC_VECTOR`.
  2. EX mispredict → EX target.
  3. `stall` → hold.
  4. `id_valid & id_is_ret & id_pred_taken` → `id_pred_target`.
  5. Otherwise `if_pc+4`.
- `redirect` is high for cases 1, 2 and 4. It is high for case 4 only if case 1 or 2 is absent.
- `BRANCH_STALL` and `BRANCH_EXCEPTION` codes in EX are treated as no-branch. They cause no redirect; `exc` is the exception source.
- RAS is a circular buffer with pointer `top` and saturating count `cnt` in 0..RAS_DEPTH.
  - Push writes `id_pc+4` and increments `top`, wrapping modulo RAS_DEPTH.
  - Pop decrements `top`.
  - Push when full overwrites the oldest entry; `cnt` stays at RAS_DEPTH.
  - Pop when empty: `id_pred_taken`=0, no state change. EX later corrects the target.
  - Push and pop in the same cycle: top entry replaced with `id_pc+4`; `cnt` and `top` unchanged.
- ID hints are ignored when any of `stall`, `exc` or EX mispredict is high. The ID instruction is either re-presented or squashed.
- RAS is not repaired on redirect.

## Timing
- Reset (asynchronous): `if_pc`=RESET_PC; `top`=0; `cnt`=0; RAS entries 0.
  - `redirect` and `id_pred_taken` evaluate to 0 under reset.
- `if_pc` updates on the rising edge after the cause.
- EX redirect costs 2 bubbles; ID return redirect costs 1.
- `id_pred_*` is valid combinationally in the same cycle as `id_is_ret`. It reflects RAS state before that cycle's pop.
- Reset asserted mid-operation clears all state immediately. It does not wait for the clock.

## Configuration
- `PC_GEN_RAS_EN` defined: RAS present as described.
- Undefined:
  - No RAS storage; `id_pred_taken`=0; `id_pred_target`=0.
  - ID hints are ignored.
  - Every JALR redirects from EX.

## Test plan
- Reset released, no stall, no redirect for 3 cycles → `if_pc` = 0x0, 0x4, 0x8, 0xC.
- `ex_valid`, BEQ, `ex_zero`=1, `ex_pc`=0x100, `ex_imm`=0x20, with `stall`=1 and `exc`=0 → `redirect`=1; next `if_pc`=0x120. Repeat with `exc`=1 → next `if_pc`=0x1C090000.
- Call at `id_pc`=0x200, then ret at ID → `id_pred_taken`=1, `id_pred_target`=0x204, `if_pc`=0x204. EX JALR with `ex_rs1`=0x205, `ex_imm`=0, pred 0x204 → no redirect.
- RAS_DEPTH=4:
  - Push 5 calls at 0x10, 0x20, 0x30, 0x40, 0x50.
  - Pop 5 times → predictions 0x54, 0x44, 0x34, 0x24, then `id_pred_taken`=0.
- EX JALR target 0x300 with `ex_pred_target`=0x204 → `redirect`=1; next `if_pc`=0x300. A simultaneous ID call does not push (`cnt` unchanged).
- Assert `rst` mid-cycle with `if_pc`=0x48 → `if_pc`=RESET_PC immediately, `cnt`=0.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: registered fetch program counter with EX branch resolution and an optional return-address stack
//
// Optional feature macro: PC_GEN_RAS_EN
//   defined   -> RAS predicts returns at ID; correctly predicted JALRs do not redirect
//   undefined -> no RAS; id_pred_* tied low; every JALR redirects from EX
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   stall                    hold if_pc; ID hints ignored
//   exc                      exception taken this cycle, fetch goes to EXC_VECTOR
//   ex_valid, ex_branch      EX instruction valid and its BRANCH_* code
//   ex_zero, ex_lt           ALU compare flags
//   ex_pc, ex_rs1, ex_imm    EX operands for target computation
//   ex_pred_taken/target     return prediction carried down from ID
//   id_valid, id_is_call,
//   id_is_ret, id_pc         ID hints for RAS push/pop
//   if_pc                    registered fetch address
//   redirect                 flush IF/ID and ID/EX this cycle
//   id_pred_taken/target     combinational return prediction (RAS top before this cycle's pop)
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h1C09_0000,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            exc,
    input  logic            ex_valid,
    input  logic [3:0]      ex_branch,
    input  logic            ex_zero,
    input  logic            ex_lt,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            id_valid,
    input  logic            id_is_call,
    input  logic            id_is_ret,
    input  logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] if_pc,
    output logic            redirect,
    output logic            id_pred_taken,
    output logic [XLEN-1:0] id_pred_target
);

    // Branch codes as defined in ctrl_encode_def.v
    localparam logic [3:0] BRANCH_NONE      = 4'd0;
    localparam logic [3:0] BRANCH_BEQ       = 4'd1;
    localparam logic [3:0] BRANCH_BNE       = 4'd2;
    localparam logic [3:0] BRANCH_BLT       = 4'd3;
    localparam logic [3:0] BRANCH_BGE       = 4'd4;
    localparam logic [3:0] BRANCH_BLTU      = 4'd5;
    localparam logic [3:0] BRANCH_BGEU      = 4'd6;
    localparam logic [3:0] BRANCH_JAL       = 4'd7;
    localparam logic [3:0] BRANCH_JALR      = 4'd8;
    localparam logic [3:0] BRANCH_STALL     = 4'd9;
    localparam logic [3:0] BRANCH_EXCEPTION = 4'd10;

    logic            taken;
    logic            is_jalr;
    logic            jalr_mis;
    logic            ex_mis;
    logic            ret_hit;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] next_pc;

    // STALL/EXCEPTION codes fall into the default: no branch, exc is the real exception source
    always_comb begin
        taken = 1'b0;
        case (ex_branch)
            BRANCH_BEQ:               taken = ex_zero;
            BRANCH_BNE:               taken = !ex_zero;
            BRANCH_BLT, BRANCH_BLTU:  taken = ex_lt;
            BRANCH_BGE, BRANCH_BGEU:  taken = !ex_lt;
            BRANCH_JAL, BRANCH_JALR:  taken = 1'b1;
            default:                  taken = 1'b0;
        endcase
    end

    assign is_jalr   = ex_branch == BRANCH_JALR;
    assign jalr_sum  = ex_rs1 + ex_imm;
    assign ex_target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;

    // Conditional branches and JAL are predicted not-taken, so any taken one is a mispredict
    assign ex_mis   = !rst && ex_valid && (is_jalr ? jalr_mis : taken);
    assign redirect = !rst && (exc || ex_mis || ret_hit);

    always_comb begin
        next_pc = exc     ? EXC_VECTOR :
                  ex_mis  ? ex_target :
                  stall   ? if_pc :
                  ret_hit ? id_pred_target :
                            if_pc + XLEN'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            if_pc <= RESET_PC;
        else
            if_pc <= next_pc;
    end

`ifdef PC_GEN_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [PW-1:0]   top_m1;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] ret_addr;
    logic            id_ok;
    logic            push;
    logic            pop;

    // top points at the next free slot; the live return address sits one below it
    assign top_m1         = top - PW'(1);
    assign ret_addr       = id_pc + XLEN'(4);
    assign id_ok          = id_valid && !stall && !exc && !ex_mis;
    assign push           = id_ok && id_is_call;
    assign pop            = id_ok && id_is_ret && cnt != '0;
    assign id_pred_taken  = !rst && id_valid && id_is_ret && cnt != '0;
    assign id_pred_target = ras[top_m1];
    assign ret_hit        = id_ok && id_is_ret && id_pred_taken;
    assign jalr_mis       = !ex_pred_taken || ex_target != ex_pred_target;

    // Full push overwrites the oldest slot (the one at top); count saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top <= '0;
            cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras[i] <= '0;
        end else if (push && pop) begin
            ras[top_m1] <= ret_addr;
        end else if (push) begin
            ras[top] <= ret_addr;
            top      <= top + PW'(1);
            if (cnt != CW'(RAS_DEPTH))
                cnt <= cnt + CW'(1);
        end else if (pop) begin
            top <= top_m1;
            cnt <= cnt - CW'(1);
        end
    end
`else
    logic unused_ok;

    assign id_pred_taken  = 1'b0;
    assign id_pred_target = '0;
    assign ret_hit        = 1'b0;
    assign jalr_mis       = 1'b1;
    assign unused_ok      = &{1'b0, ex_pred_taken, ex_pred_target, id_valid, id_is_call,
                              id_is_ret, id_pc, RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven and directed checks of the fetch PC generator
module tb_pc_gen;

    localparam logic [3:0] B_NONE = 4'd0, B_BEQ = 4'd1, B_BNE = 4'd2, B_BLT = 4'd3, B_BGE = 4'd4,
                           B_BLTU = 4'd5, B_BGEU = 4'd6, B_JAL = 4'd7, B_JALR = 4'd8,
                           B_STALL = 4'd9, B_EXC = 4'd10;
    localparam logic [31:0] EXCV = 32'h1C09_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, exc, ex_valid, ex_zero, ex_lt, ex_pred_taken;
    logic [3:0]  ex_branch;
    logic [31:0] ex_pc, ex_rs1, ex_imm, ex_pred_target, id_pc;
    logic        id_valid, id_is_call, id_is_ret;
    logic [31:0] if_pc, id_pred_target;
    logic        redirect, id_pred_taken;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .exc(exc), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .id_valid(id_valid),
        .id_is_call(id_is_call), .id_is_ret(id_is_ret), .id_pc(id_pc), .if_pc(if_pc),
        .redirect(redirect), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, ex, ev;
        logic [3:0]  br;
        logic        z, lt;
        logic [31:0] pc, rs1, imm;
        logic        pt;
        logic [31:0] ptg;
        logic        er;
        logic [31:0] et;
    } vec_t;

    function automatic vec_t mk(logic st, logic ex, logic ev, logic [3:0] br, logic z, logic lt,
                                logic [31:0] pc, logic [31:0] rs1, logic [31:0] imm, logic pt,
                                logic [31:0] ptg, logic er, logic [31:0] et);
        vec_t v;
        v.st = st; v.ex = ex; v.ev = ev; v.br = br; v.z = z; v.lt = lt; v.pc = pc; v.rs1 = rs1;
        v.imm = imm; v.pt = pt; v.ptg = ptg; v.er = er; v.et = et;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic clear();
        stall = 0; exc = 0; ex_valid = 0; ex_branch = B_NONE; ex_zero = 0; ex_lt = 0;
        ex_pc = 0; ex_rs1 = 0; ex_imm = 0; ex_pred_taken = 0; ex_pred_target = 0;
        id_valid = 0; id_is_call = 0; id_is_ret = 0; id_pc = 0;
    endtask

    // Inputs already applied; check redirect, clock once, check the model's next fetch PC
    task automatic cyc(input string nm, input logic er, input logic [31:0] et);
        logic [31:0] nxt;
        #1;
        check({nm, ".redirect"}, {31'b0, redirect}, {31'b0, er});
        nxt = er ? et : (stall ? exp_pc : exp_pc + 32'd4);
        @(posedge clk);
        #1;
        check({nm, ".if_pc"}, if_pc, nxt);
        exp_pc = nxt;
        clear();
    endtask

    task automatic call_at(input logic [31:0] pc);
        id_valid = 1; id_is_call = 1; id_pc = pc;
        cyc($sformatf("call%h", pc), 0, 0);
    endtask

    task automatic ret_pred(input string nm, input logic pt, input logic [31:0] tgt);
        id_valid = 1; id_is_ret = 1; id_pc = 32'h900;
        #1;
        check({nm, ".pred_taken"}, {31'b0, id_pred_taken}, {31'b0, pt});
        if (pt) check({nm, ".pred_target"}, id_pred_target, tgt);
        cyc(nm, pt, tgt);
    endtask

    vec_t vecs[$];

    initial begin
        clear();
        vecs.push_back(mk(1, 0, 1, B_BEQ,  1, 0, 32'h100, 0, 32'h20, 0, 0, 1, 32'h120));
        vecs.push_back(mk(1, 1, 1, B_BEQ,  1, 0, 32'h100, 0, 32'h20, 0, 0, 1, EXCV));
        vecs.push_back(mk(0, 0, 1, B_BEQ,  0, 0, 32'h100, 0, 32'h20, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_BNE,  0, 0, 32'h400, 0, 32'h10, 0, 0, 1, 32'h410));
        vecs.push_back(mk(0, 0, 1, B_BNE,  1, 0, 32'h400, 0, 32'h10, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_BLT,  0, 1, 32'h500, 0, 32'hFFFF_FFF0, 0, 0, 1, 32'h4F0));
        vecs.push_back(mk(0, 0, 1, B_BLTU, 0, 0, 32'h500, 0, 32'h8, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_BGE,  0, 0, 32'h600, 0, 32'h8, 0, 0, 1, 32'h608));
        vecs.push_back(mk(0, 0, 1, B_BGEU, 0, 1, 32'h600, 0, 32'h8, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_BGEU, 0, 0, 32'h640, 0, 32'h4, 0, 0, 1, 32'h644));
        vecs.push_back(mk(0, 0, 1, B_JAL,  0, 0, 32'h700, 0, 32'h40, 0, 0, 1, 32'h740));
        vecs.push_back(mk(0, 0, 0, B_JAL,  0, 0, 32'h700, 0, 32'h40, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_STALL, 1, 1, 32'h800, 0, 32'h40, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_EXC,  1, 1, 32'h800, 0, 32'h40, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, B_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, B_JALR, 0, 0, 32'h10, 32'h303, 32'h10, 0, 0, 1, 32'h312));
`ifdef PC_GEN_RAS_EN
        vecs.push_back(mk(0, 0, 1, B_JALR, 0, 0, 32'h10, 32'h205, 0, 1, 32'h204, 0, 0));
`else
        vecs.push_back(mk(0, 0, 1, B_JALR, 0, 0, 32'h10, 32'h205, 0, 1, 32'h204, 1, 32'h204));
`endif
        vecs.push_back(mk(0, 0, 1, B_JALR, 0, 0, 32'h10, 32'h300, 0, 1, 32'h204, 1, 32'h300));
        vecs.push_back(mk(0, 1, 0, B_NONE, 0, 0, 0, 0, 0, 0, 0, 1, EXCV));

        // Under reset: PC at reset value, outputs low even with exc asserted
        exc = 1; id_valid = 1; id_is_ret = 1;
        #12;
        check("rst.if_pc", if_pc, 32'h0);
        check("rst.redirect", {31'b0, redirect}, 32'h0);
        check("rst.pred_taken", {31'b0, id_pred_taken}, 32'h0);
        clear();
        @(negedge clk);
        rst = 0;
        exp_pc = 32'h0;
        #1;
        check("seq.if_pc0", if_pc, 32'h0);
        for (int i = 0; i < 3; i++) cyc($sformatf("seq%0d", i + 1), 0, 0);

        foreach (vecs[i]) begin
            stall = vecs[i].st; exc = vecs[i].ex; ex_valid = vecs[i].ev; ex_branch = vecs[i].br;
            ex_zero = vecs[i].z; ex_lt = vecs[i].lt; ex_pc = vecs[i].pc; ex_rs1 = vecs[i].rs1;
            ex_imm = vecs[i].imm; ex_pred_taken = vecs[i].pt; ex_pred_target = vecs[i].ptg;
            cyc($sformatf("vec%0d", i), vecs[i].er, vecs[i].et);
        end

`ifdef PC_GEN_RAS_EN
        call_at(32'h200);
        ret_pred("ret204", 1, 32'h204);
        ex_valid = 1; ex_branch = B_JALR; ex_rs1 = 32'h205; ex_pred_taken = 1; ex_pred_target = 32'h204;
        cyc("jalr_ok", 0, 0);

        for (int i = 1; i <= 5; i++) call_at(32'(i * 16));
        ret_pred("pop1", 1, 32'h54);
        ret_pred("pop2", 1, 32'h44);
        ret_pred("pop3", 1, 32'h34);
        ret_pred("pop4", 1, 32'h24);
        ret_pred("pop5", 0, 0);

        // Ret while stalled must not pop
        call_at(32'h60);
        stall = 1; id_valid = 1; id_is_ret = 1;
        cyc("ret_stall", 0, 0);
        ret_pred("after_stall", 1, 32'h64);

        // Mispredict squashes a simultaneous call
        call_at(32'h80);
        ex_valid = 1; ex_branch = B_JALR; ex_rs1 = 32'h300; ex_pred_taken = 1; ex_pred_target = 32'h204;
        id_valid = 1; id_is_call = 1; id_pc = 32'h90;
        cyc("mis_call", 1, 32'h300);
        ret_pred("mis_pop1", 1, 32'h84);
        ret_pred("mis_pop2", 0, 0);

        // Call and ret together replace the top entry
        call_at(32'hA0);
        id_valid = 1; id_is_call = 1; id_is_ret = 1; id_pc = 32'hB0;
        #1;
        check("swap.pred_target", id_pred_target, 32'hA4);
        cyc("swap", 1, 32'hA4);
        ret_pred("swap_pop1", 1, 32'hB4);
        ret_pred("swap_pop2", 0, 0);
        call_at(32'hC0);
`else
        id_valid = 1; id_is_ret = 1; id_is_call = 1; id_pc = 32'h200;
        #1;
        check("noras.pred_taken", {31'b0, id_pred_taken}, 32'h0);
        check("noras.pred_target", id_pred_target, 32'h0);
        cyc("noras", 0, 0);
`endif

        // Asynchronous reset in the middle of a cycle
        ex_valid = 1; ex_branch = B_JAL; ex_pc = 32'h0; ex_imm = 32'h48;
        cyc("to48", 1, 32'h48);
        #2;
        rst = 1;
        #1;
        check("async.if_pc", if_pc, 32'h0);
        check("async.redirect", {31'b0, redirect}, 32'h0);
        @(negedge clk);
        rst = 0;
        exp_pc = 32'h0;
        ret_pred("async.ras_empty", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
